// File: rtl/ctrl_pipe_de_if.sv
// ctrl_pipe_de_if: decode-to-execute control bundle, flag inputs and execute-stage outputs
interface ctrl_pipe_de_if #(parameter int CNT_W = 8);
  logic             StallE;
  logic             FlushE;
  logic             ValidD;
  logic [3:0]       CondD;
  logic [1:0]       FlagWD;
  logic             PCSD;
  logic             RegWD;
  logic             MemWD;
  logic             BranchD;
  logic [3:0]       FlagsNext;
  logic             FlagsLd;
  logic [3:0]       CondE;
  logic [1:0]       FlagWE;
  logic             PCSE;
  logic             RegWE;
  logic             MemWE;
  logic             BranchE;
  logic             ValidE;
  logic [3:0]       FlagsE;
  logic [CNT_W-1:0] BubbleCnt;
  modport master (
    output StallE, FlushE, ValidD, CondD, FlagWD, PCSD, RegWD, MemWD, BranchD, FlagsNext, FlagsLd,
    input  CondE, FlagWE, PCSE, RegWE, MemWE, BranchE, ValidE, FlagsE, BubbleCnt
  );
  modport slave (
    input  StallE, FlushE, ValidD, CondD, FlagWD, PCSD, RegWD, MemWD, BranchD, FlagsNext, FlagsLd,
    output CondE, FlagWE, PCSE, RegWE, MemWE, BranchE, ValidE, FlagsE, BubbleCnt
  );
endinterface

// File: rtl/ctrl_pipe_de.sv
// ctrl_pipe_de: execute-stage control register with flush/stall, NZCV flags register and bubble counter
module ctrl_pipe_de #(
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           reset,
  ctrl_pipe_de_if.slave bus
);
  logic [3:0]       cond_q;
  logic [1:0]       flagw_q;
  logic             pcs_q;
  logic             regw_q;
  logic             memw_q;
  logic             branch_q;
  logic             valid_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load;
  logic             bubble;
  assign load   = bus.FlushE | ~bus.StallE;
  assign bubble = bus.FlushE | (~bus.StallE & ~bus.ValidD);
  // Flags follow the stall only, so the instruction leaving execute still commits on a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_q   <= 4'b1110;
      flagw_q  <= 2'b00;
      pcs_q    <= 1'b0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      branch_q <= 1'b0;
      valid_q  <= 1'b0;
      flags_q  <= 4'b0000;
      cnt_q    <= '0;
    end else begin
      if (load) begin
        cond_q   <= bubble ? 4'b1110 : bus.CondD;
        flagw_q  <= bubble ? 2'b00 : bus.FlagWD;
        pcs_q    <= ~bubble & bus.PCSD;
        regw_q   <= ~bubble & bus.RegWD;
        memw_q   <= ~bubble & bus.MemWD;
        branch_q <= ~bubble & bus.BranchD;
        valid_q  <= ~bubble;
      end
      if (bus.FlagsLd && !bus.StallE) flags_q <= bus.FlagsNext;
      if (bubble && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.CondE     = cond_q;
  assign bus.FlagWE    = flagw_q;
  assign bus.PCSE      = pcs_q;
  assign bus.RegWE     = regw_q;
  assign bus.MemWE     = memw_q;
  assign bus.BranchE   = branch_q;
  assign bus.ValidE    = valid_q;
  assign bus.FlagsE    = flags_q;
  assign bus.BubbleCnt = cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_de.sv
// tb_ctrl_pipe_de: directed vectors against hand-computed expectations for ctrl_pipe_de
module tb_ctrl_pipe_de;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  ctrl_pipe_de_if #(.CNT_W(8)) bus ();
  ctrl_pipe_de #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_cond"}, bus.CondE, 4'b1110);
    chk({tag, "_flagw"}, bus.FlagWE, 2'b00);
    chk({tag, "_en"}, {bus.PCSE, bus.RegWE, bus.MemWE, bus.BranchE}, 4'b0000);
    chk({tag, "_valid"}, bus.ValidE, 1'b0);
    chk({tag, "_flags"}, bus.FlagsE, 4'b0000);
    chk({tag, "_cnt"}, bus.BubbleCnt, 8'd0);
  endtask
  initial begin
    {bus.StallE, bus.FlushE, bus.ValidD, bus.PCSD, bus.RegWD, bus.MemWD, bus.BranchD, bus.FlagsLd} = '0;
    bus.CondD = 4'h0;
    bus.FlagWD = 2'b00;
    bus.FlagsNext = 4'h0;
    #12;
    chk_reset("rst");
    bus.ValidD = 1'b1;
    bus.CondD = 4'b0000;
    bus.FlagWD = 2'b11;
    bus.RegWD = 1'b1;
    reset = 1'b1;
    step();
    chk("load_cond", bus.CondE, 4'b0000);
    chk("load_flagw", bus.FlagWE, 2'b11);
    chk("load_regw", bus.RegWE, 1'b1);
    chk("load_valid", bus.ValidE, 1'b1);
    chk("load_cnt", bus.BubbleCnt, 8'd0);
    bus.CondD = 4'h5;
    bus.RegWD = 1'b0;
    bus.StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_cond", bus.CondE, 4'b0000);
      chk("stall_regw", bus.RegWE, 1'b1);
      chk("stall_valid", bus.ValidE, 1'b1);
      chk("stall_cnt", bus.BubbleCnt, 8'd0);
    end
    bus.FlushE = 1'b1;
    step();
    chk("flst_cond", bus.CondE, 4'b1110);
    chk("flst_regw", bus.RegWE, 1'b0);
    chk("flst_valid", bus.ValidE, 1'b0);
    chk("flst_cnt", bus.BubbleCnt, 8'd1);
    bus.FlushE = 1'b0;
    bus.FlagsNext = 4'b1010;
    bus.FlagsLd = 1'b1;
    step();
    chk("flg_stall", bus.FlagsE, 4'b0000);
    chk("flg_stall_cnt", bus.BubbleCnt, 8'd1);
    bus.StallE = 1'b0;
    step();
    chk("flg_load", bus.FlagsE, 4'b1010);
    chk("flg_load_cond", bus.CondE, 4'h5);
    chk("flg_load_valid", bus.ValidE, 1'b1);
    bus.FlagsNext = 4'b0101;
    bus.FlushE = 1'b1;
    step();
    chk("flg_flush", bus.FlagsE, 4'b0101);
    chk("flg_flush_valid", bus.ValidE, 1'b0);
    chk("flg_flush_cnt", bus.BubbleCnt, 8'd2);
    bus.FlushE = 1'b0;
    bus.FlagsLd = 1'b0;
    bus.ValidD = 1'b0;
    bus.MemWD = 1'b1;
    bus.BranchD = 1'b1;
    bus.PCSD = 1'b1;
    bus.CondD = 4'h9;
    step();
    chk("empty_memw", bus.MemWE, 1'b0);
    chk("empty_branch", bus.BranchE, 1'b0);
    chk("empty_pcs", bus.PCSE, 1'b0);
    chk("empty_cond", bus.CondE, 4'b1110);
    chk("empty_valid", bus.ValidE, 1'b0);
    chk("empty_cnt", bus.BubbleCnt, 8'd3);
    chk("empty_flags", bus.FlagsE, 4'b0101);
    bus.ValidD = 1'b1;
    bus.FlagWD = 2'b01;
    step();
    chk("full_cond", bus.CondE, 4'h9);
    chk("full_flagw", bus.FlagWE, 2'b01);
    chk("full_en", {bus.PCSE, bus.RegWE, bus.MemWE, bus.BranchE}, 4'b1011);
    chk("full_cnt", bus.BubbleCnt, 8'd3);
    bus.FlushE = 1'b1;
    for (int i = 0; i < 260; i++) step();
    chk("sat_cnt", bus.BubbleCnt, 8'hFF);
    step();
    chk("sat_hold", bus.BubbleCnt, 8'hFF);
    bus.FlushE = 1'b0;
    bus.FlagsNext = 4'b1111;
    bus.FlagsLd = 1'b1;
    step();
    chk("pre_valid", bus.ValidE, 1'b1);
    chk("pre_flags", bus.FlagsE, 4'b1111);
    #2 reset = 1'b0;
    #1;
    chk_reset("async");
    bus.CondD = 4'h3;
    #2 reset = 1'b1;
    step();
    chk("post_cond", bus.CondE, 4'h3);
    chk("post_valid", bus.ValidE, 1'b1);
    chk("post_flags", bus.FlagsE, 4'b1111);
    chk("post_cnt", bus.BubbleCnt, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
